// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Stopwatch/timer control core. Decodes button-strobed 3-bit commands and owns
// the tick prescaler, the elapsed/remaining counter, the lap register and the
// countdown-done logic. Sits between debounced button/switch inputs and the
// display encoder.
//
// Parameters
//   TICK_DIV   clk cycles per count tick (>= 2)
//   CNT_W      counter / preset / lap width
//   MAX_COUNT  terminal value; up-count wraps MAX_COUNT -> 0, presets clamp to it
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   cmd_btn_i    command strobe, idle-high; a command is accepted on its falling edge
//   optiune_i    command code, sampled in the accept cycle
//   preset_i     countdown start value, sampled on LOAD
//   count_o      current counter value
//   lap_o        last captured lap value
//   lap_valid_o  one-cycle pulse after a lap capture
//   running_o    high while running
//   done_o       high once a countdown has finished
//   wrap_o       one-cycle pulse when the up-count wraps
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_btn_i,
    input  logic [2:0]       optiune_i,
    input  logic [CNT_W-1:0] preset_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] lap_o,
    output logic             lap_valid_o,
    output logic             running_o,
    output logic             done_o,
    output logic             wrap_o
);

    localparam int               PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] CMD_START   = 3'b001;
    localparam logic [2:0] CMD_PAUSE   = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_LAP     = 3'b100;
    localparam logic [2:0] CMD_LOAD    = 3'b101;
    localparam logic [2:0] CMD_MODE_UP = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_t;

    state_t           state_q,    state_d;
    mode_t            mode_q,     mode_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] lap_q,      lap_d;
    logic             lapValid_q, lapValid_d;
    logic             wrap_q,     wrap_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic             btnPrev_q;
    logic             running_q;
    logic             done_q;
    logic             accept;
    logic             tick;

    // State and datapath registers. running/done are registered decodes of
    // the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_UP;
            count_q    <= '0;
            lap_q      <= '0;
            lapValid_q <= 1'b0;
            wrap_q     <= 1'b0;
            prescale_q <= '0;
            btnPrev_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            lap_q      <= lap_d;
            lapValid_q <= lapValid_d;
            wrap_q     <= wrap_d;
            prescale_q <= prescale_d;
            btnPrev_q  <= cmd_btn_i;
            running_q  <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Next-state logic. The running tick is evaluated first; an accepted
    // command is then layered on top, so PAUSE/LAP keep a coincident tick
    // while STOP/LOAD overwrite its effect.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        count_d    = count_q;
        lap_d      = lap_q;
        lapValid_d = 1'b0;
        wrap_d     = 1'b0;
        prescale_d = prescale_q;

        accept = btnPrev_q & ~cmd_btn_i;
        tick   = (state_q == ST_RUN) && (prescale_q == PS_LAST);

        if (state_q == ST_RUN) begin
            prescale_d = tick ? '0 : prescale_q + 1'b1;
            if (tick) begin
                if (mode_q == MODE_UP) begin
                    if (count_q >= CNT_MAX) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    // Saturate at zero and finish on the 1 -> 0 step.
                    if (count_q <= CNT_ONE) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        end

        if (accept) begin
            case (optiune_i)
                CMD_START: begin
                    if (state_q == ST_IDLE) begin
                        state_d = ((mode_q == MODE_DOWN) && (count_q == '0)) ? ST_DONE : ST_RUN;
                    end else if (state_q == ST_PAUSED) begin
                        state_d = ST_RUN;
                    end
                end
                CMD_PAUSE: begin
                    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
                        state_d = ST_PAUSED;
                    end
                end
                CMD_STOP: begin
                    count_d    = '0;
                    prescale_d = '0;
                    wrap_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
                CMD_LAP: begin
                    lap_d      = count_q;
                    lapValid_d = 1'b1;
                end
                CMD_LOAD: begin
                    count_d    = (preset_i > CNT_MAX) ? CNT_MAX : preset_i;
                    mode_d     = MODE_DOWN;
                    prescale_d = '0;
                    wrap_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
                CMD_MODE_UP: begin
                    if ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) begin
                        mode_d = MODE_UP;
                        if (count_q > CNT_MAX) begin
                            count_d = CNT_MAX;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count_o     = count_q;
    assign lap_o       = lap_q;
    assign lap_valid_o = lapValid_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign wrap_o      = wrap_q;

endmodule
